mul_pipe_top: RTL and testbench

- Parametrised pipelined multiplier with valid/ready handshakes on input and output.
- Per-transaction signed or unsigned mode, plus a user tag carried alongside each operand pair.
- Generalises the fixed 16x16 register-wrapped multiplier: configurable widths and latency, plus backpressure.
- Sits between a producer such as a DSP datapath or address generator and a consumer that may stall.

---
 rtl/mul_pkg.sv | 12 +
 rtl/mul_pipe_stage.sv | 26 ++
 rtl/mul_pipe_top.sv | 96 +++++++++
 tb/tb_mul_pipe_top.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined multiplier: product-width helper and
// per-transaction arithmetic mode encoding.
package mul_pkg;

    localparam logic MUL_UNSIGNED = 1'b0;
    localparam logic MUL_SIGNED   = 1'b1;

    function automatic int prod_w(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One retiming slice {valid, data} of the multiplier pipeline; holds when en=0.
module mul_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    // NOTE: data is reset along with valid so the output bus reads 0 straight
    // out of reset; between valid beats it may load whatever arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= in_data;
        end
    end

endmodule

// File: rtl/mul_pipe_top.sv
// Pipelined signed/unsigned multiplier with valid/ready handshakes, a sideband
// tag and a single global stall enable driven by the output handshake.
module mul_pipe_top
    import mul_pkg::*;
#(
    parameter int A_W    = 16,
    parameter int B_W    = 16,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       in_a,
    input  logic [B_W-1:0]       in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W+B_W-1:0]   out_product,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    localparam int P_W = prod_w(A_W, B_W);
    localparam int D_W = P_W + TAG_W;

    logic             en;
    logic             s1_valid;
    logic [A_W-1:0]   s1_a;
    logic [B_W-1:0]   s1_b;
    logic             s1_signed;
    logic [TAG_W-1:0] s1_tag;

    logic             sign_mode;
    logic [P_W-1:0]   a_ext;
    logic [P_W-1:0]   b_ext;
    logic [P_W-1:0]   product;

    logic [STAGES-1:0] v_chain;
    logic [D_W-1:0]    d_chain [STAGES];

    // The whole pipeline freezes only when a result is waiting and unread.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_signed <= MUL_UNSIGNED;
            s1_tag    <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_a      <= in_a;
            s1_b      <= in_b;
            s1_signed <= in_signed;
            s1_tag    <= in_tag;
        end
    end

    // Extending both operands to the full product width makes a plain
    // P_W x P_W multiply exact modulo 2^P_W in either mode.
    always_comb begin
        sign_mode = (s1_signed == MUL_SIGNED);
        a_ext     = {{B_W{sign_mode & s1_a[A_W-1]}}, s1_a};
        b_ext     = {{A_W{sign_mode & s1_b[B_W-1]}}, s1_b};
        product   = a_ext * b_ext;
    end

    assign v_chain[0] = s1_valid;
    assign d_chain[0] = {product, s1_tag};

    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        mul_pipe_stage #(
            .W(D_W)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .in_valid (v_chain[k-1]),
            .in_data  (d_chain[k-1]),
            .out_valid(v_chain[k]),
            .out_data (d_chain[k])
        );
    end

    assign out_valid              = v_chain[STAGES-1];
    assign {out_product, out_tag} = d_chain[STAGES-1];
    assign busy                   = |v_chain;

endmodule

// File: tb/tb_mul_pipe_top.sv
// Directed and randomised checks of mul_pipe_top at default parameters, plus a
// second instance at A_W=8, B_W=12, STAGES=5.
module tb_mul_pipe_top;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid, in_ready, in_signed, out_valid, out_ready, busy;
    logic [15:0] in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic [31:0] out_product;

    logic        in_valid2, in_ready2, in_signed2, out_valid2, out_ready2, busy2;
    logic [7:0]  in_a2;
    logic [11:0] in_b2;
    logic [3:0]  in_tag2, out_tag2;
    logic [19:0] out_product2;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] p;
        logic [3:0]  t;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mul_pipe_top dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_tag(out_tag), .busy(busy)
    );

    mul_pipe_top #(.A_W(8), .B_W(12), .STAGES(5), .TAG_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2),
        .in_signed(in_signed2), .in_tag(in_tag2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_product(out_product2), .out_tag(out_tag2), .busy(busy2)
    );

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
        logic signed [31:0] sp;
        logic [31:0]        up;
        sp = $signed(a) * $signed(b);
        up = a * b;
        return s ? sp : up;
    endfunction

    // Apply inputs just after the falling edge and let combinational outputs settle.
    task automatic drive(input logic iv, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [3:0] tag, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_tag    = tag;
        out_ready = ordy;
        #1;
    endtask

    task automatic test_reset();
        in_valid = 0; in_a = 0; in_b = 0; in_signed = 0; in_tag = 0; out_ready = 1;
        in_valid2 = 0; in_a2 = 0; in_b2 = 0; in_signed2 = 0; in_tag2 = 0; out_ready2 = 1;
        rst_n = 0;
        #3;
        total++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            bad++;
            $display("FAIL reset_flags got v/busy/rdy=%b exp=001", {out_valid, busy, in_ready});
        end
        total++;
        if ({out_product, out_tag} !== 36'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {out_product, out_tag});
        end
        total++;
        if ({out_valid2, busy2, out_product2} !== 22'h0) begin
            bad++;
            $display("FAIL reset_dut2 got=%h exp=0", {out_valid2, busy2, out_product2});
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_unsigned_max();
        drive(1, 16'hFFFF, 16'hFFFF, 0, 4'd5, 1);
        for (int c = 1; c <= 4; c++) begin
            drive(0, 16'h0, 16'h0, 0, 4'd0, 1);
            if (c < 3 || c == 4) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL umax_valid_c%0d got=%b exp=0", c, out_valid);
                end
            end else begin
                total++;
                if ({out_valid, out_product, out_tag} !== {1'b1, 32'hFFFE0001, 4'd5}) begin
                    bad++;
                    $display("FAIL umax_result got v=%b p=%h t=%h exp v=1 p=fffe0001 t=5",
                             out_valid, out_product, out_tag);
                end
            end
        end
    endtask

    task automatic test_signed_corners();
        logic [15:0] va [3] = '{16'h8000, 16'hFFFF, 16'hFFFF};
        logic [15:0] vb [3] = '{16'h8000, 16'h0001, 16'h0001};
        logic        vs [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] ep [3] = '{32'h40000000, 32'hFFFFFFFF, 32'h0000FFFF};
        for (int c = 0; c <= 6; c++) begin
            if (c < 3) drive(1, va[c], vb[c], vs[c], 4'(c + 1), 1);
            else       drive(0, 16'h0, 16'h0, 0, 4'd0, 1);
            if (c >= 3 && c <= 5) begin
                total++;
                if ({out_valid, out_product, out_tag} !== {1'b1, ep[c-3], 4'(c - 2)}) begin
                    bad++;
                    $display("FAIL corner_%0d got v=%b p=%h t=%h exp v=1 p=%h t=%h",
                             c - 3, out_valid, out_product, out_tag, ep[c-3], 4'(c - 2));
                end
            end else if (c == 6) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL corner_tail got=%b exp=0", out_valid);
                end
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++)
            drive(1, 16'h1234 + 16'(i), 16'h0010, 0, 4'(i), 1);
        // Pipeline now full with item 0 at the output; stall for 10 cycles.
        for (int h = 0; h <= 10; h++) begin
            drive(1, 16'h1237, 16'h0010, 0, 4'd3, 0);
            total++;
            if ({in_ready, out_valid, out_product, out_tag} !== {2'b01, 32'h00012340, 4'd0}) begin
                bad++;
                $display("FAIL stall_hold_%0d got rdy=%b v=%b p=%h t=%h exp rdy=0 v=1 p=12340 t=0",
                         h, in_ready, out_valid, out_product, out_tag);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 0) drive(1, 16'h1237, 16'h0010, 0, 4'd3, 1);
            else        drive(0, 16'h0, 16'h0, 0, 4'd0, 1);
            if (k == 0) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_release_ready got=%b exp=1", in_ready);
                end
            end
            total++;
            if ({out_valid, out_product, out_tag} !== {1'b1, 32'h00012340 + 32'(16 * k), 4'(k)}) begin
                bad++;
                $display("FAIL stall_drain_%0d got v=%b p=%h t=%h exp v=1 p=%h t=%h",
                         k, out_valid, out_product, out_tag, 32'h00012340 + 32'(16 * k), 4'(k));
            end
        end
        drive(0, 16'h0, 16'h0, 0, 4'd0, 1);
        total++;
        if ({out_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL stall_empty got v/busy=%b exp=00", {out_valid, busy});
        end
    endtask

    task automatic test_random();
        int   pushed = 0;
        int   cycles = 0;
        exp_t e;
        sb_q.delete();
        while (pushed < 1000 && cycles < 20000) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            in_signed = 1'($urandom_range(0, 1));
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            cycles++;
            if (out_valid && out_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra got p=%h t=%h exp no output", out_product, out_tag);
                end else begin
                    e = sb_q.pop_front();
                    if ({out_product, out_tag} !== {e.p, e.t}) begin
                        bad++;
                        $display("FAIL rand_data got p=%h t=%h exp p=%h t=%h",
                                 out_product, out_tag, e.p, e.t);
                    end
                end
            end
            if (in_valid && in_ready)
                begin
                    sb_q.push_back('{p: ref_mul(in_a, in_b, in_signed), t: in_tag});
                    pushed++;
                end
        end
        total++;
        if (pushed != 1000) begin
            bad++;
            $display("FAIL rand_timeout got pushed=%0d exp=1000", pushed);
        end
        for (int d = 0; d < 50 && sb_q.size() > 0; d++) begin
            drive(0, 16'h0, 16'h0, 0, 4'd0, 1);
            if (out_valid) begin
                total++;
                e = sb_q.pop_front();
                if ({out_product, out_tag} !== {e.p, e.t}) begin
                    bad++;
                    $display("FAIL rand_drain got p=%h t=%h exp p=%h t=%h",
                             out_product, out_tag, e.p, e.t);
                end
            end
        end
        drive(0, 16'h0, 16'h0, 0, 4'd0, 1);
        total++;
        if (sb_q.size() != 0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rand_end got left=%0d busy=%b v=%b exp left=0 busy=0 v=0",
                     sb_q.size(), busy, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 16'h0003, 16'h0005, 0, 4'd1, 1);
        drive(1, 16'h0007, 16'h0009, 0, 4'd2, 1);
        drive(1, 16'h000B, 16'h000D, 0, 4'd3, 0);
        @(posedge clk);
        #2;
        total++;
        if ({busy, out_valid} !== 2'b11) begin
            bad++;
            $display("FAIL rstmid_pre got busy/v=%b exp=11", {busy, out_valid});
        end
        rst_n = 0;
        #1;
        total++;
        if ({out_valid, busy, out_product, out_tag} !== 38'h0) begin
            bad++;
            $display("FAIL rstmid_clear got v=%b busy=%b p=%h t=%h exp all 0",
                     out_valid, busy, out_product, out_tag);
        end
        @(negedge clk);
        in_valid  = 0;
        out_ready = 1;
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 6; c++) begin
            drive(0, 16'h0, 16'h0, 0, 4'd0, 1);
            total++;
            if ({out_valid, busy} !== 2'b00) begin
                bad++;
                $display("FAIL rstmid_stale_%0d got v/busy=%b exp=00", c, {out_valid, busy});
            end
        end
    endtask

    task automatic test_param();
        @(negedge clk);
        in_valid2  = 1;
        in_a2      = 8'h80;
        in_b2      = 12'h7FF;
        in_signed2 = 1;
        in_tag2    = 4'hA;
        out_ready2 = 1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            in_valid2 = 0;
            #1;
            if (c == 5) begin
                // -128 * 2047 = -262016, i.e. 0xFC0080 sign-extended, 0xC0080 in 20 bits.
                total++;
                if ({out_valid2, out_product2, out_tag2} !== {1'b1, 20'hC0080, 4'hA}) begin
                    bad++;
                    $display("FAIL param_result got v=%b p=%h t=%h exp v=1 p=c0080 t=a",
                             out_valid2, out_product2, out_tag2);
                end
            end else begin
                total++;
                if (out_valid2 !== 1'b0) begin
                    bad++;
                    $display("FAIL param_latency_c%0d got=%b exp=0", c, out_valid2);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed_corners();
        test_stall();
        test_random();
        test_reset_mid();
        test_param();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
